simplerisc_fetch_unit: RTL and testbench

//  Instruction-fetch front end for the SimpleRisc pipeline; sits directly upstream of the OF stage.

---
 rtl/simplerisc_pkg.sv | 34 +++
 rtl/simplerisc_sync_fifo.sv | 53 +++++
 rtl/simplerisc_fetch_unit.sv | 104 ++++++++++
 tb/tb_simplerisc_fetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRisc definitions: datapath widths, 5-bit opcodes and the fetch queue entry.
package simplerisc_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/simplerisc_sync_fifo.sv
// Synchronous FIFO with a one-cycle flush; storage is not reset, only the pointers and count.
module simplerisc_sync_fifo
    import simplerisc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                       clk1,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_din,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_dout,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [CW-1:0]     r_count;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (i_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk1) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/simplerisc_fetch_unit.sv
// SimpleRisc fetch front end: PC, fetch credits, redirect drop logic and the prefetch queue.
// Optional zero-latency response bypass is enabled by defining SIMPLERISC_FETCH_BYPASS_EN.
module simplerisc_fetch_unit
    import simplerisc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          DEPTH    = 4
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int          CW  = $clog2(DEPTH+1);
    localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_inflight;
    logic          w_empty;
    logic          w_full;
    logic          w_req_fire;
    logic          w_rsp_accept;
    logic          w_push;
    logic          w_pop;
    fetch_entry_t  w_head;
    fetch_entry_t  w_new;

    // Credits cover both queued and in-flight words so the queue can never overflow.
    assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_count};
    assign imem_req_valid = rst_n && !redirect_valid && (w_inflight < LIM);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_rsp_accept   = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop          = !w_empty && if_ready;
    assign w_new          = '{pc: r_resp_pc, instr: imem_rsp_data};

`ifdef SIMPLERISC_FETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass = w_empty && w_rsp_accept;
    assign w_push   = w_rsp_accept && !(w_bypass && if_ready);
    assign if_valid = !w_empty || w_bypass;
    assign if_pc    = !w_empty ? w_head.pc    : (w_bypass ? r_resp_pc     : '0);
    assign if_instr = !w_empty ? w_head.instr : (w_bypass ? imem_rsp_data : '0);
`else
    assign w_push   = w_rsp_accept;
    assign if_valid = !w_empty;
    assign if_pc    = w_empty ? '0 : w_head.pc;
    assign if_instr = w_empty ? '0 : w_head.instr;
`endif

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            r_fetch_pc    <= redirect_pc;
            r_resp_pc     <= redirect_pc;
            r_outstanding <= r_outstanding - CW'(imem_rsp_valid);
            r_drop_cnt    <= r_outstanding - CW'(imem_rsp_valid);
        end else begin
            if (w_req_fire)   r_fetch_pc <= r_fetch_pc + 32'd1;
            if (w_rsp_accept) r_resp_pc  <= r_resp_pc + 32'd1;
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
        end
    end

    simplerisc_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W ($bits(fetch_entry_t))
    ) u_queue (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_din   (w_new),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    a_no_overflow: assert property (@(posedge clk1) disable iff (!rst_n) !(w_push && w_full));

endmodule

// File: tb/tb_simplerisc_fetch_unit.sv
// Directed bench for simplerisc_fetch_unit with a fixed-latency in-order instruction memory model.
module tb_simplerisc_fetch_unit;

    localparam logic [31:0] KEY = 32'hDEAD_0000;
`ifdef SIMPLERISC_FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk1;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int          n_chk;
    int          n_err;
    int unsigned edge_n;
    int unsigned mem_lat;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;
    mreq_t mq[$];

    simplerisc_fetch_unit #(.RESET_PC(32'd0), .DEPTH(4)) dut (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    // Memory model: responds mem_lat edges after the request edge, in order, data = addr ^ KEY.
    initial begin
        edge_n         = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk1);
            edge_n++;
            #7;
            if (!rst_n) begin
                mq.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                if (mq.size() > 0 && mq[0].due == edge_n + 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mq[0].addr ^ KEY;
                    void'(mq.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                end
                if (imem_req_valid && imem_req_ready)
                    mq.push_back('{addr: imem_req_addr, due: edge_n + 1 + mem_lat});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_drive();
        @(posedge clk1);
        #5;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset(input string tag);
        next_drive();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        settle();
        check({tag, "_rst_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_rst_req_addr"},  imem_req_addr, 32'd0);
        check({tag, "_rst_if_valid"},  32'(if_valid), 32'd0);
        check({tag, "_rst_if_pc"},     if_pc, 32'd0);
        check({tag, "_rst_if_instr"},  if_instr, 32'd0);
        next_drive();
        next_drive();
        rst_n = 1'b1;
        settle();
        check({tag, "_first_req_valid"}, 32'(imem_req_valid), 32'd1);
        check({tag, "_first_req_addr"},  imem_req_addr, 32'd0);
    endtask

    initial begin
        int          fires;
        logic [31:0] exp_pc;
        bit          found;
        n_chk          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        mem_lat        = 1;

        // Streaming with 1-cycle memory; also checks response-to-if_valid latency.
        do_reset("stream");
        exp_pc = 32'd0;
        for (int i = 1; i <= 14; i++) begin
            next_drive();
            settle();
            if (i == 1) check("lat_if_valid", 32'(if_valid), 32'(BYP));
            else        check("stream_valid", 32'(if_valid), 32'd1);
            if (if_valid) begin
                check("stream_pc",    if_pc, exp_pc);
                check("stream_instr", if_instr, exp_pc ^ KEY);
                exp_pc++;
            end
        end

        // Backpressure: queue fills with exactly DEPTH words, then drains in order.
        if_ready = 1'b0;
        mem_lat  = 1;
        do_reset("stall");
        fires = (imem_req_valid && imem_req_ready) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            next_drive();
            settle();
            if (imem_req_valid && imem_req_ready) fires++;
        end
        check("stall_fires",     32'(fires), 32'd4);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_if_valid",  32'(if_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            next_drive();
            if_ready = 1'b1;
            settle();
            check("drain_valid", 32'(if_valid), 32'd1);
            check("drain_pc",    if_pc, 32'(k));
            check("drain_instr", if_instr, 32'(k) ^ KEY);
        end

        // Redirect with two fetches in flight on a 3-cycle memory.
        if_ready = 1'b1;
        mem_lat  = 3;
        do_reset("redir");
        next_drive();
        settle();
        next_drive();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        settle();
        check("redir_no_req", 32'(imem_req_valid), 32'd0);
        next_drive();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        settle();
        check("redir_req_addr",  imem_req_addr, 32'h40);
        check("redir_req_valid", 32'(imem_req_valid), 32'd1);
        check("redir_if_idle",   32'(if_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            next_drive();
            settle();
            if (if_valid) found = 1'b1;
        end
        check("redir_found", 32'(found), 32'd1);
        check("redir_pc",    if_pc, 32'h40);
        check("redir_instr", if_instr, 32'h40 ^ KEY);

        // Redirect coinciding with a response and a pop on a 2-cycle memory.
        mem_lat = 2;
        do_reset("rpop");
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            next_drive();
            settle();
            if (if_valid && if_pc == 32'd1) found = 1'b1;
        end
        check("rpop_sync", 32'(found), 32'd1);
        next_drive();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        settle();
        check("rpop_rsp_present", 32'(imem_rsp_valid), 32'd1);
        check("rpop_no_req",      32'(imem_req_valid), 32'd0);
        check("rpop_if_valid",    32'(if_valid), BYP ? 32'd0 : 32'd1);
        if (!BYP) check("rpop_pop_pc", if_pc, 32'd2);
        next_drive();
        redirect_valid = 1'b0;
        settle();
        check("rpop_flushed",  32'(if_valid), 32'd0);
        check("rpop_req_addr", imem_req_addr, 32'h80);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            next_drive();
            settle();
            if (if_valid) found = 1'b1;
        end
        check("rpop_found", 32'(found), 32'd1);
        check("rpop_pc",    if_pc, 32'h80);
        check("rpop_instr", if_instr, 32'h80 ^ KEY);

        // Reset asserted mid-stream, then the stream restarts at RESET_PC.
        next_drive();
        settle();
        mem_lat = 1;
        do_reset("midrst");
        exp_pc = 32'd0;
        for (int i = 1; i <= 4; i++) begin
            next_drive();
            settle();
            if (if_valid) begin
                check("midrst_pc", if_pc, exp_pc);
                exp_pc++;
            end
        end
        check("midrst_progress", 32'(exp_pc >= 32'd3), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
